// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               Holds the arbiter state encoding, the source-tag base byte,
//               the timeout counter width and a tag-byte helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    // Width of the per-state timeout counter.
    localparam int ARB_TO_W = 20;

    // Base value OR-ed with the grant id to form the source-tag byte.
    localparam logic [7:0] SRC_TAG_BASE = 8'hA0;

    // TAG is only reachable when the source-tag feature is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ACCEPT = 3'd2,
        DRAIN  = 3'd3,
        TAG    = 3'd4
    } arb_state_t;

    // Tag byte announcing which requester owns the following frame.
    function automatic logic [7:0] src_tag(input logic [3:0] id);
        return SRC_TAG_BASE | {4'h0, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               set bit of 'valid' at or after 'ptr', wrapping past N-1.
// Ports       : valid [N]  - request vector
//               ptr   [W]  - search start index (must be < N)
//               idx   [W]  - index of the winning request
//               hit        - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         hit
);

    // One extra bit so ptr + offset (< 2N) never overflows before the wrap.
    logic [W:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid wins last.
    always_comb begin
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (W+1)'(i);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (valid[cand[W-1:0]]) begin
                idx = cand[W-1:0];
                hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Frame-locked round-robin arbiter sharing one UART transmitter
//               between NUM_REQ byte producers. A grant is held until the
//               granted frame's last byte has drained through the UART, or
//               until the frame is aborted by the per-state timeout.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               req_valid/data/last - per-requester byte lanes (8 bits each)
//               req_ready           - one-hot single-cycle byte acceptance
//               tx_ready            - UART ready flag (clk domain)
//               tx_data, tx_en      - byte and level enable to the UART
//               grant_id            - current grant holder
//               busy                - any state other than IDLE
//               timeout_err         - one-cycle pulse on frame abort
// Config      : UART_TX_ARB_SRC_TAG_EN - prefix every frame with a tag byte
//               (SRC_TAG_BASE | grant_id) before the requester's bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int                  NUM_REQ     = 2,
    parameter logic [ARB_TO_W-1:0] ACK_TIMEOUT = 20'd1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      pick_idx;
    logic                pick_hit;
    logic [IDW-1:0]      next_ptr;
    logic                last_q;
    logic [ARB_TO_W-1:0] to_cnt;
    logic                to_hit;
    logic                load_fire;
    logic [7:0]          lanes [NUM_REQ];

    rr_pick #(
        .N (NUM_REQ),
        .W (IDW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .hit   (pick_hit)
    );

    // Round-robin pointer moves just past the requester that owned the frame.
    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // The counter value is the number of edges already spent in this state;
    // the abort edge is the one on which it would reach ACK_TIMEOUT.
    assign to_hit = (state != IDLE) && (to_cnt == ACK_TIMEOUT - 1'b1);

    // A byte moves on the edge where the UART is ready and the granted lane is
    // valid; suppressed on an abort edge so no byte is consumed and dropped.
    assign load_fire = (state == LOAD) && tx_ready && req_valid[grant_id] && !to_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lanes[i]     = req_data[8*i +: 8];
        assign req_ready[i] = load_fire && (grant_id == IDW'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            tx_data     <= 8'h00;
            tx_en       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            last_q      <= 1'b0;
            to_cnt      <= '0;
        end else begin
            timeout_err <= 1'b0;
            // Transitions below override this with a clear.
            to_cnt      <= (state == IDLE) ? '0 : to_cnt + 1'b1;

            if (to_hit) begin
                // Abort: remaining bytes of this frame re-arbitrate later.
                tx_en       <= 1'b0;
                timeout_err <= 1'b1;
                ptr         <= next_ptr;
                busy        <= 1'b0;
                to_cnt      <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_hit) begin
                            grant_id <= pick_idx;
                            busy     <= 1'b1;
                            to_cnt   <= '0;
`ifdef UART_TX_ARB_SRC_TAG_EN
                            state    <= TAG;
`else
                            state    <= LOAD;
`endif
                        end
                    end
                    LOAD: begin
                        if (load_fire) begin
                            tx_data <= lanes[grant_id];
                            last_q  <= req_last[grant_id];
                            tx_en   <= 1'b1;
                            to_cnt  <= '0;
                            state   <= ACCEPT;
                        end
                    end
                    ACCEPT: begin
                        if (!tx_ready) begin
                            tx_en  <= 1'b0;
                            to_cnt <= '0;
                            state  <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (tx_ready) begin
                            to_cnt <= '0;
                            if (last_q) begin
                                ptr   <= next_ptr;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
`ifdef UART_TX_ARB_SRC_TAG_EN
                    TAG: begin
                        // Tag byte never ends the frame, so DRAIN returns to LOAD.
                        if (tx_ready) begin
                            tx_data <= src_tag(4'(grant_id));
                            last_q  <= 1'b0;
                            tx_en   <= 1'b1;
                            to_cnt  <= '0;
                            state   <= ACCEPT;
                        end
                    end
`endif
                    default: begin
                        tx_en  <= 1'b0;
                        busy   <= 1'b0;
                        to_cnt <= '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with two
//               queue-backed producers and a UART model that drops tx_ready
//               2 clks after tx_en and raises it 20 clks later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [1:0]  pv;
    logic [1:0]  en;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];
    int          rr_cnt0, rr_cnt1;
    logic [1:0]  rr_seen;
    logic        prev_en;
    logic [7:0]  prev_data;
    logic        uart_stuck;
    logic        u_busy;
    int          u_cnt;

    assign req_valid = pv & en;

    uart_tx_arbiter #(
        .NUM_REQ     (2),
        .ACK_TIMEOUT (20'd50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producers: pop on the acceptance seen just before the edge.
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (rr_seen[0] && q0.size() > 0) void'(q0.pop_front());
            if (rr_seen[1] && q1.size() > 0) void'(q1.pop_front());
        end
        pv[0]          = (q0.size() > 0);
        pv[1]          = (q1.size() > 0);
        req_data[7:0]  = pv[0] ? q0[0].d : 8'h00;
        req_data[15:8] = pv[1] ? q1[0].d : 8'h00;
        req_last[0]    = pv[0] && q0[0].l;
        req_last[1]    = pv[1] && q1[0].l;
    end

    // UART model.
    always begin
        @(posedge clk);
        #2;
        if (reset || uart_stuck) begin
            tx_ready = 1'b1;
            u_busy   = 1'b0;
            u_cnt    = 0;
        end else if (u_busy) begin
            u_cnt++;
            if (u_cnt == 2) begin
                tx_ready = 1'b0;
            end else if (u_cnt == 22) begin
                tx_ready = 1'b1;
                u_busy   = 1'b0;
            end
        end else if (tx_en) begin
            u_busy = 1'b1;
            u_cnt  = 0;
        end
    end

    // Monitor: logs each byte handed to the UART and counts acceptances.
    always @(negedge clk) begin
        if (reset) begin
            log_q.delete();
            rr_cnt0 = 0;
            rr_cnt1 = 0;
            rr_seen = 2'b00;
            prev_en = 1'b0;
            prev_data = 8'h00;
        end else begin
            rr_seen = req_ready;
            if (req_ready != 2'b00) check("rr_onehot", $countones(req_ready), 1);
            rr_cnt0 += int'(req_ready[0]);
            rr_cnt1 += int'(req_ready[1]);
            if (tx_en && !prev_en) log_q.push_back({8'(grant_id), tx_data});
            if (tx_en && prev_en) check("tx_data_stable", tx_data, prev_data);
            prev_en   = tx_en;
            prev_data = tx_data;
        end
    end

    task automatic push(input int lane, input logic [7:0] d, input bit last);
        beat_t b;
        b.d = d;
        b.l = last;
        if (lane == 0) q0.push_back(b);
        else           q1.push_back(b);
    endtask

    task automatic exp_byte(input int gid, input logic [7:0] d, input bit first);
`ifdef UART_TX_ARB_SRC_TAG_EN
        if (first) exp_q.push_back({8'(gid), 8'hA0 | 8'(gid)});
`else
        if (first) begin end
`endif
        exp_q.push_back({8'(gid), d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int c = 0;
        while (!((log_q.size() >= exp_q.size()) && !busy) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(c < maxc), 1);
    endtask

    task automatic wait_tx_en(input string tag, input int maxc);
        int c = 0;
        while (!tx_en && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(tx_en), 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check({tag, "_byte"}, log_q[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] first_byte;
        reset = 1'b1; uart_stuck = 1'b0; en = 2'b11; tx_ready = 1'b1;
        pv = 2'b00; req_data = 16'h0000; req_last = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b0;

        // Single requester, three-byte frame.
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        exp_byte(0, 8'h11, 1); exp_byte(0, 8'h22, 0); exp_byte(0, 8'h33, 0);
        wait_done("t1_done", 1000);
        compare_log("t1_log");
        check("t1_rr0", rr_cnt0, 3);
        check("t1_busy", busy, 0);

        // Both valid from reset, two rounds of two-byte frames.
        do_reset();
        push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(1, 8'h81, 0); push(1, 8'h82, 1); push(1, 8'h83, 0); push(1, 8'h84, 1);
        exp_byte(0, 8'h01, 1); exp_byte(0, 8'h02, 0);
        exp_byte(1, 8'h81, 1); exp_byte(1, 8'h82, 0);
        exp_byte(0, 8'h03, 1); exp_byte(0, 8'h04, 0);
        exp_byte(1, 8'h83, 1); exp_byte(1, 8'h84, 0);
        wait_done("t2_done", 2000);
        compare_log("t2_log");
        check("t2_rr0", rr_cnt0, 4);
        check("t2_rr1", rr_cnt1, 4);

        // Requester 1 arrives mid-frame: frame lock holds it off.
        do_reset();
        push(0, 8'h21, 0); push(0, 8'h22, 0); push(0, 8'h23, 1);
        exp_byte(0, 8'h21, 1); exp_byte(0, 8'h22, 0); exp_byte(0, 8'h23, 0);
        exp_byte(1, 8'h91, 1);
        wait_tx_en("t3_first_en", 100);
        push(1, 8'h91, 1);
        n = 0;
        while (rr_cnt0 < 3 && n < 1000) begin @(negedge clk); n++; end
        check("t3_rr1_locked", rr_cnt1, 0);
        wait_done("t3_done", 1000);
        compare_log("t3_log");
        check("t3_rr1", rr_cnt1, 1);

        // UART never drops ready: frame aborted by the timeout.
        do_reset();
        uart_stuck = 1'b1;
        push(0, 8'h5A, 1);
        wait_tx_en("t4_en", 100);
        n = 0;
        while (!timeout_err && n < 200) begin @(negedge clk); n++; end
        check("t4_latency", n, 50);
        check("t4_tx_en", tx_en, 0);
        check("t4_busy", busy, 0);
        en = 2'b00;
        @(negedge clk);
        check("t4_pulse_len", timeout_err, 0);
        check("t4_idle", busy, 0);
        first_byte = (log_q.size() > 0) ? log_q[0] : 16'hFFFF;
`ifdef UART_TX_ARB_SRC_TAG_EN
        check("t4_first_byte", first_byte, 16'h00A0);
`else
        check("t4_first_byte", first_byte, 16'h005A);
`endif
        uart_stuck = 1'b0;

        // Reset asserted while waiting in ACCEPT.
        do_reset();
        en = 2'b11;
        push(1, 8'h77, 1);
        wait_tx_en("t5_en", 100);
        check("t5_pre_grant", grant_id, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx_en", tx_en, 0);
        check("t5_busy", busy, 0);
        check("t5_grant", grant_id, 0);
        reset = 1'b0;

`ifdef UART_TX_ARB_SRC_TAG_EN
        // Tagged single-byte frame from requester 1.
        do_reset();
        push(1, 8'h55, 1);
        exp_byte(1, 8'h55, 1);
        wait_done("t6_done", 1000);
        compare_log("t6_log");
        check("t6_rr1", rr_cnt1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
